// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl
// Description : Direct-mapped, write-through, no-write-allocate cache
//               controller placed in front of the RAM block. Read hits are
//               served from an internal one-word-per-line array. Read misses
//               refill the line from RAM. Every write is forwarded to RAM,
//               and a write also updates the line when it hits. Saturating
//               hit and miss counters are kept for performance monitoring.
//
// Ports       : clk, gen_reset_n           clock, async active-low reset
//               cpu_req/we/addr/wdata      CPU single-word request
//               cpu_flush                  invalidate all lines (IDLE only)
//               cpu_ready/done/rdata/hit   CPU handshake and response
//               mem_write_enable/read_enable/adress/data_in/data_out
//                                          RAM port set
//               hit_count, miss_count      saturating 16-bit statistics
//
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl #(
  parameter int bitsDirect  = 10,
  parameter int sizeBitLine = 32,
  parameter int INDEX_BITS  = 4
) (
  input  logic                   clk,
  input  logic                   gen_reset_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [bitsDirect-1:0]  cpu_addr,
  input  logic [sizeBitLine-1:0] cpu_wdata,
  input  logic                   cpu_flush,
  output logic                   cpu_ready,
  output logic                   cpu_done,
  output logic [sizeBitLine-1:0] cpu_rdata,
  output logic                   cpu_hit,
  output logic                   mem_write_enable,
  output logic                   mem_read_enable,
  output logic [bitsDirect-1:0]  mem_adress,
  output logic [sizeBitLine-1:0] mem_data_in,
  input  logic [sizeBitLine-1:0] mem_data_out,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
);

  localparam int C_LINES    = 1 << INDEX_BITS;
  localparam int C_TAG_BITS = bitsDirect - INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MEM_RD   = 3'd2,
    MEM_WAIT = 3'd3,
    MEM_WR   = 3'd4,
    RESP     = 3'd5
  } state_t;

  state_t                  r_state;
  logic [bitsDirect-1:0]   r_addr;
  logic                    r_we;
  logic [sizeBitLine-1:0]  r_wdata;
  logic [C_LINES-1:0]      r_valid;

  // Tag and data arrays hold no meaning until the matching valid bit is set,
  // so they are left without reset.
  logic [C_TAG_BITS-1:0]   r_tag_arr  [C_LINES];
  logic [sizeBitLine-1:0]  r_data_arr [C_LINES];

  logic [INDEX_BITS-1:0]   w_index;
  logic [C_TAG_BITS-1:0]   w_tag;
  logic                    w_hit;

  // Lookup always works from the registered request, so nothing on the CPU
  // inputs reaches an output combinationally.
  assign w_index = r_addr[INDEX_BITS-1:0];
  assign w_tag   = r_addr[bitsDirect-1:INDEX_BITS];
  assign w_hit   = r_valid[w_index] && (r_tag_arr[w_index] == w_tag);

  // --------------------------------------------------------------------------
  // Controller FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge gen_reset_n) begin
    if (!gen_reset_n) begin
      r_state          <= IDLE;
      r_addr           <= '0;
      r_we             <= 1'b0;
      r_wdata          <= '0;
      r_valid          <= '0;
      cpu_ready        <= 1'b1;
      cpu_done         <= 1'b0;
      cpu_rdata        <= '0;
      cpu_hit          <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_adress       <= '0;
      mem_data_in      <= '0;
      hit_count        <= '0;
      miss_count       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Flush wins over a simultaneous request; the request is dropped.
          if (cpu_flush) begin
            r_valid <= '0;
          end else if (cpu_req) begin
            r_addr    <= cpu_addr;
            r_we      <= cpu_we;
            r_wdata   <= cpu_wdata;
            cpu_ready <= 1'b0;
            r_state   <= LOOKUP;
          end
        end

        LOOKUP: begin
          cpu_hit <= w_hit;
          if (w_hit) begin
            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
          end else begin
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
          end

          if (r_we) begin
            // Write-through: every write goes to RAM.
            mem_write_enable <= 1'b1;
            mem_adress       <= r_addr;
            mem_data_in      <= r_wdata;
            r_state          <= MEM_WR;
          end else if (w_hit) begin
            cpu_rdata <= r_data_arr[w_index];
            cpu_done  <= 1'b1;
            r_state   <= RESP;
          end else begin
            mem_read_enable <= 1'b1;
            mem_adress      <= r_addr;
            r_state         <= MEM_RD;
          end
        end

        MEM_RD: begin
          mem_read_enable <= 1'b0;
          r_state         <= MEM_WAIT;
        end

        MEM_WAIT: begin
          // RAM returns the word one edge after the read strobe.
          cpu_rdata        <= mem_data_out;
          r_valid[w_index] <= 1'b1;
          cpu_done         <= 1'b1;
          r_state          <= RESP;
        end

        MEM_WR: begin
          mem_write_enable <= 1'b0;
          cpu_done         <= 1'b1;
          r_state          <= RESP;
        end

        RESP: begin
          cpu_done  <= 1'b0;
          cpu_ready <= 1'b1;
          r_state   <= IDLE;
        end

        default: begin
          cpu_done         <= 1'b0;
          cpu_ready        <= 1'b1;
          mem_write_enable <= 1'b0;
          mem_read_enable  <= 1'b0;
          r_state          <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Line storage: refilled on a read miss, updated in place on a write hit.
  // A write miss leaves the array untouched (no allocate).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (r_state == MEM_WAIT) begin
      r_tag_arr[w_index]  <= w_tag;
      r_data_arr[w_index] <= mem_data_out;
    end else if ((r_state == LOOKUP) && r_we && w_hit) begin
      r_data_arr[w_index] <= r_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_ctrl
// Description : Directed self-checking bench for cache_ctrl with a behavioural
//               one-edge-latency RAM model attached to the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl;

  logic        clk;
  logic        gen_reset_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_flush;
  logic        cpu_ready;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_hit;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [9:0]  mem_adress;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int tests_run = 0;
  int tests_failed = 0;

  cache_ctrl #(
    .bitsDirect  (10),
    .sizeBitLine (32),
    .INDEX_BITS  (4)
  ) dut (
    .clk              (clk),
    .gen_reset_n      (gen_reset_n),
    .cpu_req          (cpu_req),
    .cpu_we           (cpu_we),
    .cpu_addr         (cpu_addr),
    .cpu_wdata        (cpu_wdata),
    .cpu_flush        (cpu_flush),
    .cpu_ready        (cpu_ready),
    .cpu_done         (cpu_done),
    .cpu_rdata        (cpu_rdata),
    .cpu_hit          (cpu_hit),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_adress       (mem_adress),
    .mem_data_in      (mem_data_in),
    .mem_data_out     (mem_data_out),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data_out is valid the cycle after read_enable. The preloaded
  // words are (re)written while reset is held.
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (!gen_reset_n) begin
      ram[10'h005] <= 32'hDEADBEEF;
      ram[10'h015] <= 32'hCAFEF00D;
      mem_data_out <= 32'h0;
    end else begin
      if (mem_write_enable) ram[mem_adress] <= mem_data_in;
      if (mem_read_enable)  mem_data_out    <= ram[mem_adress];
    end
  end

  // Memory-port activity monitor, sampled mid-cycle.
  int          rd_pulses;
  int          wr_pulses;
  int          both_high;
  logic [9:0]  wr_addr_seen;
  logic [31:0] wr_data_seen;
  initial begin
    rd_pulses = 0;
    wr_pulses = 0;
    both_high = 0;
    wr_addr_seen = '0;
    wr_data_seen = '0;
  end
  always @(negedge clk) begin
    if (mem_read_enable) rd_pulses++;
    if (mem_write_enable) begin
      wr_pulses++;
      wr_addr_seen = mem_adress;
      wr_data_seen = mem_data_in;
    end
    if (mem_read_enable && mem_write_enable) both_high++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Results of the last transaction: latency counts rising edges from the
  // accepting edge (inclusive) up to the edge that raised cpu_done.
  int          lat;
  logic [31:0] got_rdata;
  logic        got_hit;

  task automatic do_req(input logic we, input logic [9:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    rd_pulses = 0;
    wr_pulses = 0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    @(posedge clk);
    lat = 1;
    #1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_wdata = '0;
    while (!cpu_done && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    if (!cpu_done) check("done_timeout", 32'(lat), 32'd0);
    got_rdata = cpu_rdata;
    got_hit   = cpu_hit;
    // Let RESP finish and return to IDLE.
    @(posedge clk);
    #1;
  endtask

  initial begin
    gen_reset_n = 1'b0;
    cpu_req     = 1'b0;
    cpu_we      = 1'b0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    cpu_flush   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    gen_reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_ready", 32'(cpu_ready), 32'd1);
    check("rst_done",  32'(cpu_done),  32'd0);
    check("rst_hitcnt", 32'(hit_count), 32'd0);
    check("rst_misscnt", 32'(miss_count), 32'd0);
    check("rst_rden", 32'(mem_read_enable), 32'd0);
    check("rst_wren", 32'(mem_write_enable), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_adress", 32'(mem_adress), 32'd0);

    // Read miss 0x005
    do_req(1'b0, 10'h005, '0);
    check("rmiss_lat",   32'(lat), 32'd4);
    check("rmiss_rdata", got_rdata, 32'hDEADBEEF);
    check("rmiss_hit",   32'(got_hit), 32'd0);
    check("rmiss_rdpulse", 32'(rd_pulses), 32'd1);
    check("rmiss_wrpulse", 32'(wr_pulses), 32'd0);
    check("rmiss_misscnt", 32'(miss_count), 32'd1);
    check("rmiss_ready_back", 32'(cpu_ready), 32'd1);

    // Read hit 0x005
    do_req(1'b0, 10'h005, '0);
    check("rhit_lat",   32'(lat), 32'd2);
    check("rhit_rdata", got_rdata, 32'hDEADBEEF);
    check("rhit_hit",   32'(got_hit), 32'd1);
    check("rhit_rdpulse", 32'(rd_pulses), 32'd0);
    check("rhit_hitcnt", 32'(hit_count), 32'd1);

    // Write hit 0x005
    do_req(1'b1, 10'h005, 32'h12345678);
    check("whit_lat", 32'(lat), 32'd3);
    check("whit_hit", 32'(got_hit), 32'd1);
    check("whit_wrpulse", 32'(wr_pulses), 32'd1);
    check("whit_rdpulse", 32'(rd_pulses), 32'd0);
    check("whit_addr", 32'(wr_addr_seen), 32'h005);
    check("whit_data", wr_data_seen, 32'h12345678);
    check("whit_hitcnt", 32'(hit_count), 32'd2);

    // Read 0x005 after write: hit with updated data
    do_req(1'b0, 10'h005, '0);
    check("rafterw_hit", 32'(got_hit), 32'd1);
    check("rafterw_rdata", got_rdata, 32'h12345678);
    check("rafterw_hitcnt", 32'(hit_count), 32'd3);

    // Conflict: 0x015 maps to index 5
    do_req(1'b0, 10'h015, '0);
    check("conf_hit", 32'(got_hit), 32'd0);
    check("conf_rdata", got_rdata, 32'hCAFEF00D);
    check("conf_misscnt", 32'(miss_count), 32'd2);
    do_req(1'b0, 10'h005, '0);
    check("conf_back_hit", 32'(got_hit), 32'd0);
    check("conf_back_rdata", got_rdata, 32'h12345678);
    check("conf_back_lat", 32'(lat), 32'd4);

    // Write miss 0x020 then read: still a miss (no allocate)
    do_req(1'b1, 10'h020, 32'hA5A5A5A5);
    check("wmiss_lat", 32'(lat), 32'd3);
    check("wmiss_hit", 32'(got_hit), 32'd0);
    check("wmiss_misscnt", 32'(miss_count), 32'd4);
    do_req(1'b0, 10'h020, '0);
    check("wmiss_rd_hit", 32'(got_hit), 32'd0);
    check("wmiss_rd_rdata", got_rdata, 32'hA5A5A5A5);
    check("wmiss_rd_rdpulse", 32'(rd_pulses), 32'd1);
    do_req(1'b0, 10'h020, '0);
    check("cached_hit", 32'(got_hit), 32'd1);
    check("cached_hitcnt", 32'(hit_count), 32'd4);

    // Flush with a simultaneous request: request dropped
    @(negedge clk);
    cpu_flush = 1'b1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 10'h020;
    @(posedge clk);
    #1;
    cpu_flush = 1'b0;
    cpu_req   = 1'b0;
    check("flush_ready", 32'(cpu_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("flush_nodone", 32'(cpu_done), 32'd0);
    check("flush_hitcnt", 32'(hit_count), 32'd4);
    check("flush_misscnt", 32'(miss_count), 32'd5);
    do_req(1'b0, 10'h020, '0);
    check("postflush_hit", 32'(got_hit), 32'd0);
    check("postflush_rdata", got_rdata, 32'hA5A5A5A5);
    check("postflush_misscnt", 32'(miss_count), 32'd6);

    check("never_both_en", 32'(both_high), 32'd0);

    // Reset during MEM_RD
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 10'h015;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_rden_before", 32'(mem_read_enable), 32'd1);
    gen_reset_n = 1'b0;
    #1;
    check("midrst_rden_after", 32'(mem_read_enable), 32'd0);
    check("midrst_ready", 32'(cpu_ready), 32'd1);
    check("midrst_misscnt", 32'(miss_count), 32'd0);
    @(negedge clk);
    gen_reset_n = 1'b1;
    begin
      int done_seen;
      done_seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (cpu_done) done_seen++;
      end
      check("midrst_nodone", 32'(done_seen), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
